// File: rtl/mmcm_sup_pkg.sv
// ============================================================================
//  Module   : mmcm_sup_pkg
//  Brief    : Shared types and widths for the MMCM lock supervisor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmcm_sup_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 8;
    localparam int LOSS_W  = 16;

    // Encodings are visible on state_o, so the values are pinned explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_RST_MMCM  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAIL      = 3'd5
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mmcm_lock_supervisor_bit_sync.sv
// ============================================================================
//  Module   : bit_sync
//  Brief    : Two-flop synchronizer for a single asynchronous level signal.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic r_meta;
    (* ASYNC_REG = "TRUE" *) logic r_sync;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/mmcm_lock_supervisor.sv
// ============================================================================
//  Module   : mmcm_lock_supervisor
//  Brief    : Sequences MMCM reset, waits for and qualifies lock with timeout
//             and bounded retries, then releases N_CH reset lines staggered.
//             Lock loss re-asserts all resets and restarts the sequence.
//             Optional sticky irq enabled by macro MMCM_SUPERVISOR_IRQ_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmcm_lock_supervisor
    import mmcm_sup_pkg::*;
#(
    parameter int N_CH             = 4,
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int STAGE_GAP_CYC    = 64,
    parameter int MAX_RETRY        = 7,
    parameter int CNT_W            = 17
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                mmcm_locked_in,
    input  logic                force_relock,
    input  logic                irq_clr,
    output logic                mmcm_rst_out,
    output logic [N_CH-1:0]     ch_rst,
    output logic                ready,
    output logic                fail,
    output logic [RETRY_W-1:0]  retry_cnt,
    output logic [LOSS_W-1:0]   loss_cnt,
    output logic [STATE_W-1:0]  state_o,
    output logic                irq
);

    localparam logic [N_CH-1:0]    c_ch_all     = '1;
    localparam logic [N_CH-1:0]    c_ch_first   = c_ch_all << 1;
    localparam logic [CNT_W-1:0]   c_hold_last  = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]   c_tmo_last   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0]   c_stab_last  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0]   c_gap_last   = CNT_W'(STAGE_GAP_CYC - 1);
    localparam logic [RETRY_W-1:0] c_max_retry  = RETRY_W'(MAX_RETRY);
    localparam logic [LOSS_W-1:0]  c_loss_max   = '1;

    logic               w_lk;
    logic               w_lock_lost;
    logic               w_irq_set;
    state_e             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [N_CH-1:0]    r_ch_rst, w_ch_rst_nxt;
    logic [RETRY_W-1:0] r_retry, w_retry_nxt, w_retry_inc;
    logic [LOSS_W-1:0]  r_loss, w_loss_nxt;
    logic               r_mmcm_rst;
    logic               r_ready;
    logic               r_fail;

    bit_sync u_lock_sync (
        .clk (clk_in),
        .rst (reset),
        .i_d (mmcm_locked_in),
        .o_q (w_lk)
    );

    assign w_retry_inc = r_retry + RETRY_W'(1);

    // Next-state, timer, channel-reset and counter updates.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_ch_rst_nxt = r_ch_rst;
        w_retry_nxt  = r_retry;
        w_loss_nxt   = r_loss;
        w_irq_set    = 1'b0;
        w_lock_lost  = 1'b0;

        if (force_relock) begin
            // A restart request outranks any lock loss or timeout this cycle.
            w_state_nxt  = ST_RST_MMCM;
            w_timer_nxt  = '0;
            w_ch_rst_nxt = c_ch_all;
            w_retry_nxt  = '0;
        end else begin
            case (r_state)
                ST_RST_MMCM: begin
                    w_ch_rst_nxt = c_ch_all;
                    if (r_timer == c_hold_last) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    w_ch_rst_nxt = c_ch_all;
                    if (w_lk) begin
                        w_state_nxt = ST_STABLE;
                        w_timer_nxt = '0;
                    end else if (r_timer == c_tmo_last) begin
                        w_retry_nxt = w_retry_inc;
                        w_timer_nxt = '0;
                        if (w_retry_inc == c_max_retry) begin
                            w_state_nxt = ST_FAIL;
                            w_irq_set   = 1'b1;
                        end else begin
                            w_state_nxt = ST_RST_MMCM;
                        end
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    w_ch_rst_nxt = c_ch_all;
                    if (!w_lk) begin
                        // Lock never fully qualified, so this is not a loss.
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else if (r_timer == c_stab_last) begin
                        w_state_nxt  = ST_RELEASE;
                        w_timer_nxt  = '0;
                        w_ch_rst_nxt = c_ch_first;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!w_lk) begin
                        w_lock_lost = 1'b1;
                    end else if (!r_ch_rst[N_CH-1]) begin
                        w_state_nxt = ST_RUN;
                        w_retry_nxt = '0;
                    end else if (r_timer == c_gap_last) begin
                        // Channels release LSB first: shifting in zeros.
                        w_ch_rst_nxt = r_ch_rst << 1;
                        w_timer_nxt  = '0;
                    end else begin
                        w_timer_nxt = r_timer + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    w_ch_rst_nxt = '0;
                    if (!w_lk) begin
                        w_lock_lost = 1'b1;
                    end
                end
                ST_FAIL: begin
                    w_ch_rst_nxt = c_ch_all;
                end
                default: begin
                    w_state_nxt  = ST_RST_MMCM;
                    w_timer_nxt  = '0;
                    w_ch_rst_nxt = c_ch_all;
                end
            endcase

            if (w_lock_lost) begin
                w_state_nxt  = ST_RST_MMCM;
                w_timer_nxt  = '0;
                w_ch_rst_nxt = c_ch_all;
                w_irq_set    = 1'b1;
                if (r_loss != c_loss_max) begin
                    w_loss_nxt = r_loss + LOSS_W'(1);
                end
            end
        end
    end

    // State register plus registered outputs decoded from the next state.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state    <= ST_RST_MMCM;
            r_timer    <= '0;
            r_ch_rst   <= c_ch_all;
            r_retry    <= '0;
            r_loss     <= '0;
            r_mmcm_rst <= 1'b1;
            r_ready    <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_ch_rst   <= w_ch_rst_nxt;
            r_retry    <= w_retry_nxt;
            r_loss     <= w_loss_nxt;
            r_mmcm_rst <= (w_state_nxt == ST_RST_MMCM) || (w_state_nxt == ST_FAIL);
            r_ready    <= (w_state_nxt == ST_RUN);
            r_fail     <= (w_state_nxt == ST_FAIL);
        end
    end

`ifdef MMCM_SUPERVISOR_IRQ_EN
    logic r_irq;

    // Sticky flag; a new event wins over a clear in the same cycle.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`else
    logic w_unused_irq;
    assign w_unused_irq = irq_clr ^ w_irq_set;
    assign irq          = 1'b0;
`endif

    assign mmcm_rst_out = r_mmcm_rst;
    assign ch_rst       = r_ch_rst;
    assign ready        = r_ready;
    assign fail         = r_fail;
    assign retry_cnt    = r_retry;
    assign loss_cnt     = r_loss;
    assign state_o      = r_state;

endmodule

`default_nettype wire

// File: doc/mmcm_lock_supervisor.md
Name: mmcm_lock_supervisor

Overview:
- Single-clock supervisor for an MMCM-based clock generator. Sequences the MMCM reset and waits for lock with a timeout and bounded retries.
- Qualifies lock for stability, then releases N_CH downstream reset lines in staggered order.
- Handles lock loss by re-asserting every reset and restarting the sequence.
- Runs on the free-running reference clock, next to the clock-generation wrapper.

Parameters:
- N_CH, 4: number of staged reset outputs (1..16).
- RST_HOLD_CYC, 16: cycles mmcm_rst_out is held high per attempt (>=1).
- LOCK_TIMEOUT_CYC, 100000: maximum cycles to wait for lock per attempt.
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock cycles required before any release.
- STAGE_GAP_CYC, 64: cycles between successive channel releases (>=1).
- MAX_RETRY, 7: failed attempts before entering FAIL (1..255).
- CNT_W, 17: internal timer width; must hold max(LOCK_TIMEOUT_CYC, LOCK_STABLE_CYC).

Ports:
- clk_in  in  1  free-running reference clock.
- reset  in  1  synchronous, active-high reset.
- mmcm_locked_in  in  1  raw MMCM LOCKED, asynchronous to clk_in.
- force_relock  in  1  single-cycle request to restart the sequence.
- irq_clr  in  1  clears the sticky irq (used only with the optional feature).
- mmcm_rst_out  out  1  MMCM RST drive.
- ch_rst  out  N_CH  per-channel active-high resets.
- ready  out  1  high only in RUN.
- fail  out  1  high only in FAIL.
- retry_cnt  out  8  failed attempts since the last RUN or force_relock.
- loss_cnt  out  16  lock losses since reset, saturating at 16'hFFFF.
- state_o  out  3  current state encoding.
- irq  out  1  sticky lock-loss/fail flag.

Behaviour:
- Reset and clocking:
  - Reset is synchronous and active-high; there is one clock, clk_in.
  - Reset values: state=RST_MMCM, mmcm_rst_out=1, ch_rst=all 1s, ready=0, fail=0, retry_cnt=0, loss_cnt=0, irq=0, timer=0.
  - Reset mid-operation returns to these values on the next edge.
- Lock synchronizer:
  - mmcm_locked_in passes through a 2-flop synchronizer to give lk.
  - lk lags the raw input by 2 cycles; all decisions below use lk.
- State machine:
  - RST_MMCM (0): mmcm_rst_out=1, ch_rst all 1s. After RST_HOLD_CYC cycles, go to WAIT_LOCK with timer cleared.
  - WAIT_LOCK (1): mmcm_rst_out=0.
    - If lk=1, go to STABLE.
    - If timer reaches LOCK_TIMEOUT_CYC-1 with lk=0, increment retry_cnt. If the new value equals MAX_RETRY, go to FAIL; otherwise go to RST_MMCM.
  - STABLE (2): counts consecutive lk=1 cycles. When the count reaches LOCK_STABLE_CYC, go to RELEASE. If lk=0, restart from WAIT_LOCK; this is not counted as a loss.
  - RELEASE (3):
    - ch_rst[0] deasserts on entry.
    - Each further channel i deasserts STAGE_GAP_CYC cycles after channel i-1.
    - Once ch_rst[N_CH-1] deasserts, go to RUN on the next cycle; retry_cnt clears on entry to RUN.
  - RUN (4): ready=1 and all ch_rst=0.
  - FAIL (5): fail=1, mmcm_rst_out=1, ch_rst all 1s. Leaves only on reset or force_relock.
- Lock loss: lk=0 seen in RELEASE or RUN.
  - In the same registered update: ch_rst goes to all 1s, ready goes to 0, state goes to RST_MMCM, and loss_cnt increments (saturating).
  - Channel resets therefore reassert 3 cycles after the raw LOCKED falls.
- force_relock: in any state, go to RST_MMCM and clear retry_cnt; loss_cnt is unchanged.
- Simultaneous events: force_relock has priority over lock loss and timeout. A lock loss coinciding with force_relock does not count as a loss.
- N_CH=1: RELEASE lasts one cycle.

Optional Feature:
- Macro: MMCM_SUPERVISOR_IRQ_EN.
- With the macro defined:
  - irq sets on any counted lock loss or on entry to FAIL, and stays high until irq_clr.
  - If a set and irq_clr occur in the same cycle, irq stays set.
- Without the macro: irq is tied to 0 and irq_clr is ignored.

Decomposition:
- Package mmcm_sup_pkg holds:
  - the state enum (3-bit; RST_MMCM=0 through FAIL=5);
  - the STATE_W, RETRY_W=8 and LOSS_W=16 constants.
- One sub-module, bit_sync: a 2-flop synchronizer with its flops marked ASYNC_REG, used for mmcm_locked_in.

Test Plan (N_CH=4, RST_HOLD=4, TIMEOUT=50, STABLE=8, GAP=3, MAX_RETRY=2):
- Nominal:
  - Stimulus: raw lock rises 10 cycles after mmcm_rst_out falls.
  - Response: ch_rst goes 1110, 1100, 1000, 0000 with 3-cycle spacing; ready=1 one cycle after 0000; retry_cnt=0.
- Timeout/fail:
  - Stimulus: lock never rises.
  - Response: two 50-cycle WAIT_LOCK windows; retry_cnt goes 1 then 2; fail=1; state_o=5; mmcm_rst_out=1.
- Lock loss in RUN:
  - Stimulus: drop raw lock.
  - Response: ch_rst=1111 and ready=0 three cycles later; loss_cnt=1; the full sequence replays after lock returns.
- Glitch in STABLE:
  - Stimulus: a 1-cycle lock dropout at stable count 5.
  - Response: the stable counter restarts; loss_cnt stays 0; release is delayed accordingly.
- force_relock:
  - Stimulus: force_relock in FAIL.
  - Response: retry_cnt=0 and the RST_MMCM hold lasts 4 cycles.
  - Stimulus: force_relock in RUN, same cycle as a lock drop.
  - Response: loss_cnt is unchanged.
- IRQ (with MMCM_SUPERVISOR_IRQ_EN):
  - Stimulus: a lock loss.
  - Response: irq=1 and stays set until an irq_clr pulse.
  - Stimulus: a loss coinciding with irq_clr.
  - Response: irq stays 1.
